// File: rtl/rf_stage_if.sv
// rf_stage_if: signal bundle between the Beta RF stage and its neighbours
// (fetch upstream, ALU/MEM/WB downstream). The RF stage is the slave side.

`ifndef INST_NOP
`define INST_NOP 32'h83FF_F800
`endif
`ifndef IR_SRC_DATA
`define IR_SRC_DATA 2'd0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 2'd1
`endif
`ifndef IR_SRC_EXCEPT
`define IR_SRC_EXCEPT 2'd2
`endif

interface rf_stage_if;
  // fetch -> RF
  logic        irq;
  logic [31:0] if_inst;
  logic [31:0] if_pc_plus_four;

  // RF -> fetch
  logic [5:0]  opcode;
  logic        ill_op;
  logic        zero;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic [1:0]  ir_src_rf;
  logic        stall;

  // downstream stages -> RF (bypass and write-back)
  logic [31:0] alu_result;
  logic [4:0]  mem_rc;
  logic        mem_wr;
  logic [31:0] mem_result;
  logic [4:0]  wb_rc;
  logic        wb_wr;
  logic [31:0] wb_data;

  // RF -> ALU pipeline register
  logic [31:0] ex_inst;
  logic [31:0] ex_pc_plus_four;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_lit;
  logic [4:0]  ex_rc;
  logic        ex_wr;
  logic        ex_is_load;

  modport slave (
    input  irq, if_inst, if_pc_plus_four,
    input  alu_result, mem_rc, mem_wr, mem_result, wb_rc, wb_wr, wb_data,
    output opcode, ill_op, zero, branch_addr, jump_addr, ir_src_rf, stall,
    output ex_inst, ex_pc_plus_four, ex_a, ex_b, ex_lit, ex_rc, ex_wr, ex_is_load
  );

  modport master (
    output irq, if_inst, if_pc_plus_four,
    output alu_result, mem_rc, mem_wr, mem_result, wb_rc, wb_wr, wb_data,
    input  opcode, ill_op, zero, branch_addr, jump_addr, ir_src_rf, stall,
    input  ex_inst, ex_pc_plus_four, ex_a, ex_b, ex_lit, ex_rc, ex_wr, ex_is_load
  );
endinterface

// File: rtl/rf_stage.sv
// rf_stage: Beta register-fetch/decode stage. Holds the IF/RF register and the
// 32x32 register file, bypasses from EX/MEM/WB, resolves branches and jumps,
// detects load-use hazards and launches operands into the RF/ALU register.

`ifndef INST_NOP
`define INST_NOP 32'h83FF_F800
`endif
`ifndef IR_SRC_DATA
`define IR_SRC_DATA 2'd0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 2'd1
`endif
`ifndef IR_SRC_EXCEPT
`define IR_SRC_EXCEPT 2'd2
`endif

module rf_stage #(
  parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
  input logic       clk,
  input logic       rst,
  rf_stage_if.slave bus
);

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;
  localparam logic [4:0] R31    = 5'd31;

  // IF/RF pipeline register
  logic [31:0] rf_inst;
  logic [31:0] rf_pc4;

  // register file storage; R31 is never written and always reads as zero
  logic [31:0] regs [0:31];

  // decoded fields of the instruction sitting in RF
  logic [5:0]  op;
  logic [4:0]  rc;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [4:0]  p2_addr;
  logic [15:0] lit;
  logic [31:0] lit_sext;

  logic        legal;
  logic        is_st;
  logic        is_load;
  logic        ra_used;
  logic        p2_used;
  logic        writes_rc;

  logic [31:0] a_val;
  logic [31:0] p2_val;
  logic        zero_i;
  logic        taken;
  logic        hazard_a;
  logic        hazard_p2;
  logic        stall_i;

  // The legal set is a handful of 0x18-0x1F codes plus every 0x20-0x3F code
  // whose low three bits are not all ones.
  function automatic logic is_legal(input logic [5:0] o);
    case (o)
      6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F: is_legal = 1'b1;
      default:                                  is_legal = o[5] && (o[2:0] != 3'b111);
    endcase
  endfunction

  // Newest producer wins: EX, then MEM, then WB, then the array. R31 is
  // hardwired to zero and never matches a producer.
  function automatic logic [31:0] bypass(
    input logic [4:0]  addr,
    input logic [31:0] arr_val,
    input logic        ex_wr_i,
    input logic [4:0]  ex_rc_i,
    input logic [31:0] ex_val,
    input logic        mem_wr_i,
    input logic [4:0]  mem_rc_i,
    input logic [31:0] mem_val,
    input logic        wb_wr_i,
    input logic [4:0]  wb_rc_i,
    input logic [31:0] wb_val
  );
    if (addr == R31)                          bypass = 32'd0;
    else if (ex_wr_i && (ex_rc_i == addr))    bypass = ex_val;
    else if (mem_wr_i && (mem_rc_i == addr))  bypass = mem_val;
    else if (wb_wr_i && (wb_rc_i == addr))    bypass = wb_val;
    else                                      bypass = arr_val;
  endfunction

  assign op       = rf_inst[31:26];
  assign rc       = rf_inst[25:21];
  assign ra       = rf_inst[20:16];
  assign rb       = rf_inst[15:11];
  assign lit      = rf_inst[15:0];
  assign lit_sext = {{16{lit[15]}}, lit};

  assign legal     = is_legal(op);
  assign is_st     = (op == OP_ST);
  assign is_load   = (op == OP_LD) || (op == OP_LDR);
  assign ra_used   = legal && (op != OP_LDR);
  assign p2_addr   = is_st ? rc : rb;
  assign p2_used   = is_st || (op[5:4] == 2'b10);
  assign writes_rc = legal && !is_st && (rc != R31);

  // Operand read with bypassing for both register-file ports
  always_comb begin
    a_val  = bypass(ra, regs[ra], bus.ex_wr, bus.ex_rc, bus.alu_result,
                    bus.mem_wr, bus.mem_rc, bus.mem_result,
                    bus.wb_wr, bus.wb_rc, bus.wb_data);
    p2_val = bypass(p2_addr, regs[p2_addr], bus.ex_wr, bus.ex_rc, bus.alu_result,
                    bus.mem_wr, bus.mem_rc, bus.mem_result,
                    bus.wb_wr, bus.wb_rc, bus.wb_data);
  end

  // A load in EX cannot forward its data yet, so a dependent RF instruction
  // waits one cycle until the load reaches MEM.
  assign hazard_a  = ra_used && (ra != R31) && (bus.ex_rc == ra);
  assign hazard_p2 = p2_used && (p2_addr != R31) && (bus.ex_rc == p2_addr);
  assign stall_i   = bus.ex_is_load && bus.ex_wr && (hazard_a || hazard_p2);

  assign zero_i = (a_val == 32'd0);
  assign taken  = (op == OP_JMP) ||
                  ((op == OP_BEQ) && zero_i) ||
                  ((op == OP_BNE) && !zero_i);

  assign bus.opcode      = op;
  assign bus.ill_op      = !legal;
  assign bus.zero        = zero_i;
  assign bus.branch_addr = rf_pc4 + {lit_sext[29:0], 2'b00};
  assign bus.jump_addr   = a_val & ~32'h3;
  assign bus.stall       = stall_i;

  // Fetch IR select: a stall keeps fetch's data path, otherwise an interrupt
  // beats an illegal op or taken control transfer, which squash the next fetch.
  always_comb begin
    bus.ir_src_rf = `IR_SRC_DATA;
    if (!stall_i) begin
      if (bus.irq)
        bus.ir_src_rf = `IR_SRC_EXCEPT;
      else if (!legal || taken)
        bus.ir_src_rf = `IR_SRC_NOP;
    end
  end

  // Register file write port; the write is also visible same-cycle via bypass
  always_ff @(posedge clk) begin
    if (bus.wb_wr && (bus.wb_rc != R31))
      regs[bus.wb_rc] <= bus.wb_data;
  end

  // IF/RF register: holds its instruction for the duration of a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_inst <= `INST_NOP;
      rf_pc4  <= RESET_PC4;
    end else if (!stall_i) begin
      rf_inst <= bus.if_inst;
      rf_pc4  <= bus.if_pc_plus_four;
    end
  end

  // RF/ALU register: loads every cycle, with a bubble in place of a stalled op
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_inst         <= `INST_NOP;
      bus.ex_pc_plus_four <= 32'd0;
      bus.ex_a            <= 32'd0;
      bus.ex_b            <= 32'd0;
      bus.ex_lit          <= 32'd0;
      bus.ex_rc           <= 5'd0;
      bus.ex_wr           <= 1'b0;
      bus.ex_is_load      <= 1'b0;
    end else if (stall_i) begin
      bus.ex_inst         <= `INST_NOP;
      bus.ex_pc_plus_four <= rf_pc4;
      bus.ex_a            <= 32'd0;
      bus.ex_b            <= 32'd0;
      bus.ex_lit          <= 32'd0;
      bus.ex_rc           <= R31;
      bus.ex_wr           <= 1'b0;
      bus.ex_is_load      <= 1'b0;
    end else begin
      bus.ex_inst         <= rf_inst;
      bus.ex_pc_plus_four <= rf_pc4;
      bus.ex_a            <= a_val;
      bus.ex_b            <= p2_val;
      bus.ex_lit          <= lit_sext;
      bus.ex_rc           <= rc;
      bus.ex_wr           <= writes_rc;
      bus.ex_is_load      <= legal && is_load;
    end
  end

endmodule

// File: tb/tb_rf_stage.sv
// tb_rf_stage: scoreboard bench for rf_stage. Each stimulus step pushes the
// values it expects (tagged with the cycle they are due) and a negedge monitor
// pops and compares them against the DUT.

`ifndef INST_NOP
`define INST_NOP 32'h83FF_F800
`endif
`ifndef IR_SRC_DATA
`define IR_SRC_DATA 2'd0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 2'd1
`endif
`ifndef IR_SRC_EXCEPT
`define IR_SRC_EXCEPT 2'd2
`endif

module tb_rf_stage;

  localparam logic [31:0] RESET_PC4 = 32'h0000_0004;
  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_ILL = 6'h27;

  typedef enum logic [3:0] {
    S_EX_INST, S_EX_PC4, S_EX_A, S_EX_B, S_EX_LIT, S_EX_RC, S_EX_WR, S_EX_LOAD,
    S_OPCODE, S_ILL, S_ZERO, S_BADDR, S_JADDR, S_IRSRC, S_STALL
  } sel_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  int          sb_due [$];
  sel_t        sb_sel [$];
  string       sb_tag [$];
  logic [31:0] sb_exp [$];

  rf_stage_if bus ();

  rf_stage #(.RESET_PC4(RESET_PC4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] opc(input logic [5:0] op, input logic [4:0] rc,
                                      input logic [4:0] ra, input logic [4:0] rb);
    return {op, rc, ra, rb, 11'd0};
  endfunction

  function automatic logic [31:0] opl(input logic [5:0] op, input logic [4:0] rc,
                                      input logic [4:0] ra, input logic [15:0] lit);
    return {op, rc, ra, lit};
  endfunction

  function automatic logic [31:0] observe(input sel_t s);
    case (s)
      S_EX_INST: return bus.ex_inst;
      S_EX_PC4:  return bus.ex_pc_plus_four;
      S_EX_A:    return bus.ex_a;
      S_EX_B:    return bus.ex_b;
      S_EX_LIT:  return bus.ex_lit;
      S_EX_RC:   return {27'd0, bus.ex_rc};
      S_EX_WR:   return {31'd0, bus.ex_wr};
      S_EX_LOAD: return {31'd0, bus.ex_is_load};
      S_OPCODE:  return {26'd0, bus.opcode};
      S_ILL:     return {31'd0, bus.ill_op};
      S_ZERO:    return {31'd0, bus.zero};
      S_BADDR:   return bus.branch_addr;
      S_JADDR:   return bus.jump_addr;
      S_IRSRC:   return {30'd0, bus.ir_src_rf};
      default:   return {31'd0, bus.stall};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expectOut(input int delta, input sel_t s, input string tag, input logic [31:0] v);
    sb_due.push_back(cyc + delta);
    sb_sel.push_back(s);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic quietInputs();
    bus.irq        = 1'b0;
    bus.alu_result = 32'd0;
    bus.mem_rc     = 5'd0;
    bus.mem_wr     = 1'b0;
    bus.mem_result = 32'd0;
    bus.wb_rc      = 5'd0;
    bus.wb_wr      = 1'b0;
    bus.wb_data    = 32'd0;
  endtask

  // Advance one cycle and present a new fetch word; side inputs return to idle
  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc4);
    @(posedge clk);
    #1;
    bus.if_inst         = inst;
    bus.if_pc_plus_four = pc4;
    quietInputs();
  endtask

  // Scoreboard monitor: compare every expectation due in this cycle
  always @(negedge clk) begin
    for (int i = sb_due.size() - 1; i >= 0; i--) begin
      if (sb_due[i] <= cyc) begin
        checkOutput(sb_tag[i], observe(sb_sel[i]), sb_exp[i]);
        sb_due.delete(i);
        sb_sel.delete(i);
        sb_tag.delete(i);
        sb_exp.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.if_inst = `INST_NOP;
    bus.if_pc_plus_four = 32'd0;
    quietInputs();

    // reset held across two edges
    applyStimulus(`INST_NOP, 32'd0);
    expectOut(0, S_EX_INST, "rst_ex_inst", `INST_NOP);
    expectOut(0, S_EX_WR,   "rst_ex_wr",   32'd0);
    expectOut(0, S_EX_PC4,  "rst_ex_pc4",  32'd0);
    expectOut(0, S_STALL,   "rst_stall",   32'd0);
    expectOut(0, S_IRSRC,   "rst_ir_src",  {30'd0, `IR_SRC_DATA});
    applyStimulus(`INST_NOP, 32'd0);
    rst = 1'b0;
    expectOut(0, S_OPCODE, "rst_opcode", 32'h20);
    expectOut(0, S_BADDR,  "rst_branch_addr", 32'hFFFF_E004);

    // bypass priority EX > MEM > WB > array on R1
    applyStimulus(opc(OP_ADD, 5'd1, 5'd31, 5'd31), 32'h10);
    applyStimulus(opc(OP_ADD, 5'd2, 5'd1, 5'd1), 32'h14);
    expectOut(1, S_EX_WR, "add_r1_ex_wr", 32'd1);
    applyStimulus(opc(OP_ADD, 5'd4, 5'd1, 5'd1), 32'h18);
    bus.alu_result = 32'd7;
    bus.mem_rc = 5'd1; bus.mem_wr = 1'b1; bus.mem_result = 32'd6;
    bus.wb_rc  = 5'd1; bus.wb_wr  = 1'b1; bus.wb_data    = 32'd5;
    expectOut(1, S_EX_A,   "bypass_ex_a",  32'd7);
    expectOut(1, S_EX_B,   "bypass_ex_b",  32'd7);
    expectOut(1, S_EX_RC,  "bypass_rc",    32'd2);
    expectOut(1, S_EX_PC4, "bypass_pc4",   32'h14);
    applyStimulus(opc(OP_ADD, 5'd4, 5'd1, 5'd1), 32'h1C);
    bus.alu_result = 32'd7;
    bus.mem_rc = 5'd1; bus.mem_wr = 1'b1; bus.mem_result = 32'd6;
    bus.wb_rc  = 5'd1; bus.wb_wr  = 1'b1; bus.wb_data    = 32'd5;
    expectOut(1, S_EX_A, "bypass_mem_a", 32'd6);
    applyStimulus(opc(OP_ADD, 5'd6, 5'd31, 5'd1), 32'h20);
    bus.alu_result = 32'd7;
    bus.mem_rc = 5'd1; bus.mem_wr = 1'b0; bus.mem_result = 32'd6;
    bus.wb_rc  = 5'd1; bus.wb_wr  = 1'b1; bus.wb_data    = 32'd5;
    expectOut(1, S_EX_A, "bypass_wb_a", 32'd5);
    applyStimulus(`INST_NOP, 32'h24);
    bus.mem_rc = 5'd31; bus.mem_wr = 1'b1; bus.mem_result = 32'h99;
    bus.wb_rc  = 5'd31; bus.wb_wr  = 1'b1; bus.wb_data    = 32'h77;
    expectOut(1, S_EX_A,  "r31_reads_zero", 32'd0);
    expectOut(1, S_EX_B,  "array_read_r1",  32'd5);
    expectOut(1, S_EX_WR, "add_rc_nonzero_wr", 32'd1);

    // load-use stall on Ra, then MEM forwarding of the load data
    applyStimulus(opl(OP_LD, 5'd3, 5'd31, 16'h0000), 32'h40);
    applyStimulus(opc(OP_ADD, 5'd4, 5'd3, 5'd31), 32'h44);
    expectOut(0, S_STALL,   "ld_in_rf_no_stall", 32'd0);
    expectOut(1, S_EX_LOAD, "ld_ex_is_load",     32'd1);
    applyStimulus(opc(OP_ADD, 5'd5, 5'd31, 5'd31), 32'h48);
    bus.irq = 1'b1;
    expectOut(0, S_STALL,   "load_use_stall",  32'd1);
    expectOut(0, S_IRSRC,   "stall_ir_src",    {30'd0, `IR_SRC_DATA});
    expectOut(1, S_EX_INST, "bubble_inst",     `INST_NOP);
    expectOut(1, S_EX_WR,   "bubble_wr",       32'd0);
    expectOut(1, S_EX_LOAD, "bubble_is_load",  32'd0);
    applyStimulus(opc(OP_ADD, 5'd5, 5'd31, 5'd31), 32'h48);
    bus.mem_rc = 5'd3; bus.mem_wr = 1'b1; bus.mem_result = 32'hCAFE_0003;
    expectOut(0, S_STALL,   "stall_one_cycle",  32'd0);
    expectOut(1, S_EX_A,    "load_data_bypass", 32'hCAFE_0003);
    expectOut(1, S_EX_PC4,  "held_pc4",         32'h44);
    expectOut(1, S_EX_INST, "held_inst",        opc(OP_ADD, 5'd4, 5'd3, 5'd31));

    // branches with R2 == 0, then R2 != 0
    applyStimulus(opl(OP_BEQ, 5'd31, 5'd2, 16'hFFFF), 32'h100);
    applyStimulus(opl(OP_BNE, 5'd31, 5'd2, 16'hFFFF), 32'h100);
    bus.wb_rc = 5'd2; bus.wb_wr = 1'b1; bus.wb_data = 32'd0;
    expectOut(0, S_ZERO,  "beq_zero",     32'd1);
    expectOut(0, S_BADDR, "beq_target",   32'h0000_00FC);
    expectOut(0, S_IRSRC, "beq_taken",    {30'd0, `IR_SRC_NOP});
    expectOut(1, S_EX_WR, "beq_no_write", 32'd0);
    applyStimulus(opl(OP_BEQ, 5'd31, 5'd2, 16'h0001), 32'h200);
    expectOut(0, S_ZERO,  "bne_zero",      32'd1);
    expectOut(0, S_BADDR, "bne_target",    32'h0000_00FC);
    expectOut(0, S_IRSRC, "bne_not_taken", {30'd0, `IR_SRC_DATA});
    applyStimulus(opl(OP_JMP, 5'd31, 5'd5, 16'h0000), 32'h300);
    bus.wb_rc = 5'd2; bus.wb_wr = 1'b1; bus.wb_data = 32'd5;
    expectOut(0, S_ZERO,  "beq_nonzero",     32'd0);
    expectOut(0, S_BADDR, "beq_fwd_target",  32'h0000_0204);
    expectOut(0, S_IRSRC, "beq_not_taken",   {30'd0, `IR_SRC_DATA});

    // JMP, then JMP with a simultaneous interrupt
    applyStimulus(opl(OP_JMP, 5'd31, 5'd5, 16'h0000), 32'h304);
    bus.wb_rc = 5'd5; bus.wb_wr = 1'b1; bus.wb_data = 32'h0000_1237;
    expectOut(0, S_JADDR, "jmp_addr",  32'h0000_1234);
    expectOut(0, S_IRSRC, "jmp_taken", {30'd0, `IR_SRC_NOP});
    applyStimulus(opc(OP_ILL, 5'd7, 5'd31, 5'd31), 32'h308);
    bus.irq = 1'b1;
    expectOut(0, S_JADDR, "jmp_irq_addr", 32'h0000_1234);
    expectOut(0, S_IRSRC, "jmp_irq",      {30'd0, `IR_SRC_EXCEPT});

    // illegal opcode 0x27
    applyStimulus(opl(OP_LD, 5'd31, 5'd31, 16'h0000), 32'h40C);
    expectOut(0, S_ILL,     "ill_op",        32'd1);
    expectOut(0, S_OPCODE,  "ill_opcode",    32'h27);
    expectOut(0, S_IRSRC,   "ill_ir_src",    {30'd0, `IR_SRC_NOP});
    expectOut(1, S_EX_WR,   "ill_no_write",  32'd0);
    expectOut(1, S_EX_INST, "ill_launched",  opc(OP_ILL, 5'd7, 5'd31, 5'd31));

    // load to R31 in EX never stalls
    applyStimulus(opc(OP_ADD, 5'd8, 5'd31, 5'd31), 32'h410);
    expectOut(0, S_ILL,     "ld_legal",        32'd0);
    expectOut(1, S_EX_LOAD, "ld_r31_is_load",  32'd1);
    expectOut(1, S_EX_WR,   "ld_r31_no_write", 32'd0);
    applyStimulus(`INST_NOP, 32'h414);
    expectOut(0, S_STALL, "r31_no_stall", 32'd0);

    // ST reads rc on port 2; LDR literal sign extension
    applyStimulus(opl(OP_ST, 5'd9, 5'd31, 16'h0010), 32'h500);
    applyStimulus(opl(OP_LDR, 5'd10, 5'd31, 16'h8000), 32'h504);
    bus.wb_rc = 5'd9; bus.wb_wr = 1'b1; bus.wb_data = 32'h55;
    expectOut(1, S_EX_B,   "st_port2_rc", 32'h55);
    expectOut(1, S_EX_WR,  "st_no_write", 32'd0);
    expectOut(1, S_EX_LIT, "st_lit",      32'h10);
    applyStimulus(`INST_NOP, 32'h508);
    expectOut(1, S_EX_LOAD, "ldr_is_load",  32'd1);
    expectOut(1, S_EX_LIT,  "ldr_lit_sext", 32'hFFFF_8000);
    expectOut(1, S_EX_WR,   "ldr_write",    32'd1);

    // load-use on Rb, with reset asserted during the stall
    applyStimulus(opl(OP_LD, 5'd11, 5'd31, 16'h0000), 32'h600);
    applyStimulus(opc(OP_ADD, 5'd12, 5'd31, 5'd11), 32'h604);
    applyStimulus(`INST_NOP, 32'h608);
    expectOut(0, S_STALL, "rb_load_use_stall", 32'd1);
    rst = 1'b1;
    applyStimulus(`INST_NOP, 32'h60C);
    rst = 1'b0;
    expectOut(0, S_STALL,   "rst_clears_stall", 32'd0);
    expectOut(0, S_EX_INST, "rst_mid_ex_inst",  `INST_NOP);
    expectOut(0, S_BADDR,   "rst_mid_pc4",      32'hFFFF_E004);

    applyStimulus(`INST_NOP, 32'h700);
    applyStimulus(`INST_NOP, 32'h704);
    @(negedge clk);
    #1;
    while (sb_due.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: never compared, due cycle %0d", sb_tag[0], sb_due[0]);
      void'(sb_due.pop_front());
      void'(sb_sel.pop_front());
      void'(sb_tag.pop_front());
      void'(sb_exp.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
